// File: rtl/param_updown_counter.sv
// Multi-mode unsigned counter: wrap by 1 or STEP, saturating count, load and hold.
// Every output is registered and updated on the same rising edge of clk.
module param_updown_counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned STEP  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load,
  output logic             sat
);

  typedef enum logic [2:0] {
    M_UP1   = 3'b000,
    M_DOWN1 = 3'b001,
    M_UPN   = 3'b010,
    M_LOAD  = 3'b011,
    M_DOWNN = 3'b100,
    M_SATUP = 3'b101,
    M_SATDN = 3'b110,
    M_HOLD  = 3'b111
  } mode_e;

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] ONES     = '1;

  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt, load_nxt, sat_nxt;
  logic [WIDTH:0]   sum_n;
  logic             q_max, q_zero;

  // Carry of the by-STEP add comes from the extra top bit, never a truncated value.
  assign sum_n  = {1'b0, Q} + STEP_EXT;
  assign q_max  = (Q == ONES);
  assign q_zero = (Q == '0);

  always_comb begin
    q_nxt    = Q;
    rco_nxt  = 1'b0;
    load_nxt = 1'b0;
    sat_nxt  = 1'b0;
    case (mode_e'(mode))
      M_UP1: begin
        q_nxt   = Q + 1'b1;
        rco_nxt = q_max;
      end
      M_DOWN1: begin
        q_nxt   = Q - 1'b1;
        rco_nxt = q_zero;
      end
      M_UPN: begin
        q_nxt   = sum_n[WIDTH-1:0];
        rco_nxt = sum_n[WIDTH];
      end
      M_LOAD: begin
        q_nxt    = D;
        load_nxt = 1'b1;
      end
      M_DOWNN: begin
        q_nxt   = Q - STEP_EXT[WIDTH-1:0];
        rco_nxt = ({1'b0, Q} < STEP_EXT);
      end
      M_SATUP: begin
        q_nxt   = q_max ? Q : Q + 1'b1;
        sat_nxt = q_max;
      end
      M_SATDN: begin
        q_nxt   = q_zero ? Q : Q - 1'b1;
        sat_nxt = q_zero;
      end
      default: q_nxt = Q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Q    <= '0;
      rco  <= 1'b0;
      load <= 1'b0;
      sat  <= 1'b0;
    end else if (enable) begin
      Q    <= q_nxt;
      rco  <= rco_nxt;
      load <= load_nxt;
      sat  <= sat_nxt;
    end else begin
      rco  <= 1'b0;
      load <= 1'b0;
      sat  <= 1'b0;
    end
  end

  mode_known_a: assert property (@(posedge clk) (reset && enable) |-> !$isunknown(mode))
    else $error("mode is X/Z while enabled");

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed test of param_updown_counter (WIDTH=8, STEP=3) with hand-computed expectations.
module tb_param_updown_counter;
  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] D;
  logic [7:0] Q;
  logic       rco, load, sat;

  int n_assert = 0;
  int n_fail   = 0;

  param_updown_counter #(.WIDTH(8), .STEP(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
    .Q(Q), .rco(rco), .load(load), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic en, input logic [2:0] m, input logic [7:0] d);
    reset  = rst;
    enable = en;
    mode   = m;
    D      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] eq, input logic er,
                            input logic el, input logic es);
    chk({tag, ".Q"},    32'(Q),    32'(eq));
    chk({tag, ".rco"},  32'(rco),  32'(er));
    chk({tag, ".load"}, 32'(load), 32'(el));
    chk({tag, ".sat"},  32'(sat),  32'(es));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; mode = 3'b011; D = 8'hAA;
    step(0, 1, 3'b011, 8'hAA);
    step(0, 1, 3'b011, 8'hAA); expect_out("reset",   8'h00, 0, 0, 0);

    step(1, 1, 3'b011, 8'hFE); expect_out("ld_fe",   8'hFE, 0, 1, 0);
    step(1, 1, 3'b000, 8'h00); expect_out("up1_a",   8'hFF, 0, 0, 0);
    step(1, 1, 3'b000, 8'h00); expect_out("up1_b",   8'h00, 1, 0, 0);
    step(1, 1, 3'b000, 8'h00); expect_out("up1_c",   8'h01, 0, 0, 0);

    step(1, 1, 3'b011, 8'h02); expect_out("ld_02",   8'h02, 0, 1, 0);
    step(1, 1, 3'b001, 8'h00); expect_out("dn1_a",   8'h01, 0, 0, 0);
    step(1, 1, 3'b001, 8'h00); expect_out("dn1_b",   8'h00, 0, 0, 0);
    step(1, 1, 3'b001, 8'h00); expect_out("dn1_c",   8'hFF, 1, 0, 0);
    step(1, 1, 3'b011, 8'h04); expect_out("ld_04",   8'h04, 0, 1, 0);
    step(1, 1, 3'b100, 8'h00); expect_out("dnN_a",   8'h01, 0, 0, 0);
    step(1, 1, 3'b100, 8'h00); expect_out("dnN_b",   8'hFE, 1, 0, 0);

    step(1, 1, 3'b011, 8'hFC); expect_out("ld_fc",   8'hFC, 0, 1, 0);
    step(1, 1, 3'b010, 8'h00); expect_out("upN_fc",  8'hFF, 0, 0, 0);
    step(1, 1, 3'b011, 8'hFD); expect_out("ld_fd",   8'hFD, 0, 1, 0);
    step(1, 1, 3'b010, 8'h00); expect_out("upN_fd",  8'h00, 1, 0, 0);
    step(1, 1, 3'b011, 8'hFF); expect_out("ld_ff",   8'hFF, 0, 1, 0);
    step(1, 1, 3'b010, 8'h00); expect_out("upN_ff",  8'h02, 1, 0, 0);

    step(1, 1, 3'b011, 8'hFE); expect_out("ld_fe2",  8'hFE, 0, 1, 0);
    step(1, 1, 3'b101, 8'h00); expect_out("satup_a", 8'hFF, 0, 0, 0);
    step(1, 1, 3'b101, 8'h00); expect_out("satup_b", 8'hFF, 0, 0, 1);
    step(1, 1, 3'b101, 8'h00); expect_out("satup_c", 8'hFF, 0, 0, 1);
    step(1, 1, 3'b011, 8'h01); expect_out("ld_01",   8'h01, 0, 1, 0);
    step(1, 1, 3'b110, 8'h00); expect_out("satdn_a", 8'h00, 0, 0, 0);
    step(1, 1, 3'b110, 8'h00); expect_out("satdn_b", 8'h00, 0, 0, 1);

    for (int i = 1; i <= 5; i++) step(1, 1, 3'b000, 8'h00);
    expect_out("cnt_05", 8'h05, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 3'b000, 8'h77); expect_out("freeze", 8'h05, 0, 0, 0);
    end
    step(1, 1, 3'b111, 8'h77); expect_out("hold",    8'h05, 0, 0, 0);

    step(1, 1, 3'b011, 8'hFE); expect_out("ld_fe3",  8'hFE, 0, 1, 0);
    step(0, 1, 3'b010, 8'h00); expect_out("mid_rst", 8'h00, 0, 0, 0);
    step(1, 1, 3'b111, 8'h00); expect_out("post_rst", 8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous multi-mode counter: wrapping up/down count by 1 or by STEP, saturating up/down count, parallel load, and hold.
- Next-generation counter DUT for the counter testbench/scoreboard environment.
- Registered ripple-carry (rco), load-indicator and saturation-flag outputs allow cascading and checking.

Parameters:
- WIDTH, 8, counter width in bits; legal values 2..32.
- STEP, 3, increment/decrement for the by-STEP modes; legal values 1..2^WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  count enable; 0 = freeze.
- mode  input  3  operation select (see Behaviour).
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  counter value (registered).
- rco  output  1  carry/borrow-out pulse from a wrapping operation (registered).
- load  output  1  high for the cycle following a load (registered).
- sat  output  1  high when the last saturating operation clamped (registered).

Behaviour:
- Reset:
  - reset is synchronous, active-low; clock is clk.
  - On a rising edge with reset==0: Q=0, rco=0, load=0, sat=0.
  - Reset overrides enable and mode.
  - Asserting reset mid-count clears all outputs on that edge; no partial operation completes.
- Freeze: reset==1 and enable==0 -> Q holds its value; rco=0, load=0, sat=0.
- Active operation: reset==1 and enable==1. One operation per edge, with single-cycle latency (the result is visible after the edge). rco, load and sat default to 0 each cycle unless the mode sets them.
  - 000 up1: Q<=Q+1 mod 2^WIDTH; rco=1 iff Q was all-ones.
  - 001 down1: Q<=Q-1 mod 2^WIDTH; rco=1 iff Q was 0.
  - 010 upN: Q<=(Q+STEP) mod 2^WIDTH; rco=1 iff Q+STEP >= 2^WIDTH. Compute at WIDTH+1 bits, with no truncation before the compare.
  - 011 load: Q<=D; load=1; rco=0.
  - 100 downN: Q<=(Q-STEP) mod 2^WIDTH; rco=1 iff Q < STEP.
  - 101 sat-up: Q<=min(Q+1, 2^WIDTH-1); sat=1 iff Q was already all-ones (clamp occurred); rco=0.
  - 110 sat-down: Q<=max(Q-1, 0); sat=1 iff Q was already 0; rco=0.
  - 111 hold: Q unchanged; all flags 0.
- rco, load and sat are each single-cycle pulses. They repeat on consecutive cycles only if the condition recurs, e.g. sat stays 1 while sat-up is held at max.
- Arithmetic is unsigned. All output registers are updated together on the same edge.
- X or Z on mode while enabled is unsupported; simulation should flag it with an assertion.

Test Plan:
- Defaults (WIDTH=8, STEP=3) for all scenarios below.
- Reset: reset=0 for 2 cycles with enable=1, mode=011, D=8'hAA -> Q=00, rco=0, load=0, sat=0; reset has priority.
- Up wrap: load D=FE (next cycle Q=FE, load=1), then mode 000 x3 -> Q=FF/rco=0, Q=00/rco=1, Q=01/rco=0; load=0 throughout.
- Down wrap and downN: load 02, mode 001 x3 -> 01, 00, FF with rco=1 only on the FF cycle. Then load 04, mode 100 x2 -> 01/rco=0, FE/rco=1.
- upN boundary: load FC, mode 010 -> FF/rco=0. Load FD, mode 010 -> 00/rco=1. Load FF, mode 010 -> 02/rco=1.
- Saturation: load FE, mode 101 x3 -> FF/sat=0, FF/sat=1, FF/sat=1. Load 01, mode 110 x2 -> 00/sat=0, 00/sat=1. rco=0 in all cases.
- Freeze and mid-operation reset:
  - Count to 05 with mode 000, then enable=0 for 3 cycles -> Q=05, all flags 0.
  - Set enable=1 with mode 111 -> Q=05.
  - Assert reset=0 during mode 010 with Q=FE -> Q=00, rco=0 on that edge.
